bus_master_port: RTL and testbench

- Serial master-side port of the system bus. Sits directly downstream of the bridge address converter.
- Accepts one parallel transaction at a time: a 16-bit bus address, 8-bit write data and a mode bit.
- Requests the bus from the arbiter, shifts the address (and write data) out bit-serially, collects serial read data, and reports completion or error back to the bridge.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_shift_reg.sv | 47 ++++
 rtl/bus_master_port.sv | 220 ++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and defaults for the serial bus master port
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_AACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF    = 255;

endpackage

// File: rtl/bus_shift_reg.sv
// rtl/bus_shift_reg.sv - load / shift-out / shift-in register with bit counter
//   clk, rst          : clock, synchronous active-high reset
//   load, load_data   : parallel load, also clears the bit counter
//   shift, sin        : shift right one place, sin enters at the MSB
//   last_idx          : bit index at which last asserts
//   sout              : current LSB (serial output)
//   data_next         : value the register takes on a shift
//   last              : bit counter equals last_idx
module bus_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             sin,
  input  logic [CNT_W-1:0] last_idx,
  output logic             sout,
  output logic [WIDTH-1:0] data_next,
  output logic             last
);

  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;

  // LSB-first on both directions: shifting right exposes the next bit to
  // send and, after WIDTH shifts, leaves the first received bit at bit 0.
  assign data_next = {sin, data_q[WIDTH-1:1]};
  assign sout      = data_q[0];
  assign last      = (cnt_q == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      cnt_q  <= '0;
    end else if (shift) begin
      data_q <= data_next;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - serial master-side port of the system bus
//   clk, rst                         : clock, synchronous active-high reset
//   d_req, d_addr, d_wdata, d_mode   : bridge transaction, taken while d_ready
//   d_ready, d_done, d_err, d_rdata  : bridge handshake and completion status
//   m_breq, m_bgrant                 : arbiter request / grant
//   m_wdata, m_mode, m_valid         : serial address / write-data out, LSB first
//   s_ack, s_rdata, s_rvalid         : slave acknowledge and serial read data
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_mode,
  output logic                  d_ready,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_breq,
  input  logic                  m_bgrant,
  output logic                  m_wdata,
  output logic                  m_mode,
  output logic                  m_valid,
  input  logic                  s_ack,
  input  logic                  s_rdata,
  input  logic                  s_rvalid
);

  localparam int TX_CW = $clog2(ADDR_WIDTH);
  localparam int RX_CW = $clog2(DATA_WIDTH);
  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   mode_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            tmo_q;
  logic                  tmo_hit;

  logic                  latch;
  logic                  rdata_load;
  logic                  tx_load, tx_shift, tx_sout, tx_last;
  logic [ADDR_WIDTH-1:0] tx_load_data;
  logic [ADDR_WIDTH-1:0] tx_next_unused;
  logic [TX_CW-1:0]      tx_last_idx;
  logic                  rx_load, rx_shift, rx_last;
  logic                  rx_sout_unused;
  logic [DATA_WIDTH-1:0] rx_next;

  // The TX register carries the address first, then is reloaded with the
  // zero-extended write data; only the bit count that ends the phase differs.
  assign tx_last_idx = (state_q == ST_WDATA) ? TX_CW'(DATA_WIDTH - 1)
                                             : TX_CW'(ADDR_WIDTH - 1);

  bus_shift_reg #(.WIDTH(ADDR_WIDTH), .CNT_W(TX_CW)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (tx_load_data),
    .shift     (tx_shift),
    .sin       (1'b0),
    .last_idx  (tx_last_idx),
    .sout      (tx_sout),
    .data_next (tx_next_unused),
    .last      (tx_last)
  );

  bus_shift_reg #(.WIDTH(DATA_WIDTH), .CNT_W(RX_CW)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (rx_load),
    .load_data ('0),
    .shift     (rx_shift),
    .sin       (s_rdata),
    .last_idx  (RX_CW'(DATA_WIDTH - 1)),
    .sout      (rx_sout_unused),
    .data_next (rx_next),
    .last      (rx_last)
  );

  assign tmo_hit = (tmo_q == TMO_MAX);
  assign latch   = (state_q == ST_IDLE) && d_req;
  assign rx_load = latch;

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    tx_load      = 1'b0;
    tx_load_data = '0;
    tx_shift     = 1'b0;
    rx_shift     = 1'b0;
    rdata_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          tx_load      = 1'b1;
          tx_load_data = d_addr;
          err_d        = 1'b0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_bgrant) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (!m_bgrant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          tx_shift = 1'b1;
          if (tx_last) state_d = ST_AACK;
        end
      end
      ST_AACK: begin
        if (!m_bgrant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (s_ack) begin
          if (mode_q == MODE_WRITE) begin
            tx_load      = 1'b1;
            tx_load_data = ADDR_WIDTH'(wdata_q);
            state_d      = ST_WDATA;
          end else begin
            state_d = ST_RDATA;
          end
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_WDATA: begin
        if (!m_bgrant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          tx_shift = 1'b1;
          if (tx_last) state_d = ST_WACK;
        end
      end
      ST_WACK: begin
        if (!m_bgrant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (s_ack) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_RDATA: begin
        // Grant loss wins over a coincident final bit so a truncated read
        // never reaches d_rdata.
        if (!m_bgrant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (s_rvalid) begin
          rx_shift = 1'b1;
          if (rx_last) begin
            rdata_load = 1'b1;
            state_d    = ST_DONE;
            err_d      = 1'b0;
          end
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      mode_q  <= MODE_READ;
      wdata_q <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (latch) begin
        mode_q  <= d_mode;
        wdata_q <= d_wdata;
      end
      if (rdata_load) rdata_q <= rx_next;
      // Cleared on every state entry and on each received bit; holds at
      // TMO_MAX rather than wrapping.
      if ((state_d != state_q) || rx_shift) tmo_q <= '0;
      else if (!tmo_hit)                    tmo_q <= tmo_q + 8'd1;
    end
  end

  assign d_ready = (state_q == ST_IDLE);
  assign d_done  = (state_q == ST_DONE);
  assign d_err   = d_done & err_q;
  assign d_rdata = rdata_q;
  assign m_breq  = (state_q == ST_REQ)   || (state_q == ST_ADDR)  ||
                   (state_q == ST_AACK)  || (state_q == ST_WDATA) ||
                   (state_q == ST_WACK)  || (state_q == ST_RDATA);
  assign m_valid = (state_q == ST_ADDR) || (state_q == ST_WDATA);
  assign m_wdata = m_valid & tx_sout;
  assign m_mode  = m_valid & mode_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - directed self-checking bench for bus_master_port
module tb_bus_master_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_mode;
  logic        d_ready, d_done, d_err;
  logic [7:0]  d_rdata;
  logic        m_breq, m_bgrant, m_wdata, m_mode, m_valid;
  logic        s_ack, s_rdata, s_rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(255)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_mode   (d_mode),
    .d_ready  (d_ready),
    .d_done   (d_done),
    .d_err    (d_err),
    .d_rdata  (d_rdata),
    .m_breq   (m_breq),
    .m_bgrant (m_bgrant),
    .m_wdata  (m_wdata),
    .m_mode   (m_mode),
    .m_valid  (m_valid),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata),
    .s_rvalid (s_rvalid)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from the current IDLE cycle with grant and acks
  // always high and read bits back to back; returns in the DONE cycle.
  task automatic run_txn(input logic [15:0] addr, input logic [7:0] wd,
                         input logic mode, input logic [7:0] rd,
                         input int pulse_at, output int lat, output logic err,
                         output logic [15:0] a_seen, output logic [7:0] w_seen);
    int vcnt;
    vcnt = 0; lat = -1; err = 1'b0; a_seen = '0; w_seen = '0;
    m_bgrant = 1'b1; s_ack = 1'b1; s_rvalid = 1'b1; s_rdata = 1'b0;
    d_req = 1'b1; d_addr = addr; d_wdata = wd; d_mode = mode;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0 && d_done === 1'b1) begin
        lat = c;
        err = d_err;
        break;
      end
      if (m_valid === 1'b1) begin
        if (vcnt < 16)      a_seen[vcnt] = m_wdata;
        else if (vcnt < 24) w_seen[vcnt-16] = m_wdata;
        vcnt++;
      end
      if (c >= 19 && c <= 26) s_rdata = rd[c-19];
      if (c == pulse_at) begin
        d_req = 1'b1; d_addr = 16'hFFFF; d_wdata = ~wd; d_mode = ~mode;
      end else if (c > 0) begin
        d_req = 1'b0;
      end
      step;
    end
    s_ack = 1'b0; s_rvalid = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; d_req = 1'b0; d_addr = '0; d_wdata = '0; d_mode = 1'b0;
    m_bgrant = 1'b0; s_ack = 1'b0; s_rdata = 1'b0; s_rvalid = 1'b0;
    step; step;
    rst = 1'b0;
    checks++;
    if ({d_ready, m_breq, m_valid, m_wdata, m_mode, d_done, d_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {d_ready, m_breq, m_valid, m_wdata, m_mode, d_done, d_err});
    end
    checks++;
    if (d_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00", d_rdata);
    end
  endtask

  task automatic test_write;
    logic [15:0] a_seen;
    logic [7:0]  w_seen;
    logic        ok;
    ok = 1'b1;
    d_req = 1'b1; d_addr = 16'h2ABC; d_wdata = 8'h5A; d_mode = 1'b1; m_bgrant = 1'b0;
    step;
    d_req = 1'b0;
    checks++;
    if (d_ready !== 1'b0 || m_breq !== 1'b1) begin
      errors++; $display("FAIL write_req: ready=%b breq=%b expected 0 1", d_ready, m_breq);
    end
    for (int i = 0; i < 3; i++) begin
      if (m_breq !== 1'b1 || m_valid !== 1'b0) ok = 1'b0;
      m_bgrant = (i == 2);
      step;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_breq !== 1'b1 || m_valid !== 1'b1 || m_mode !== 1'b1) ok = 1'b0;
      a_seen[i] = m_wdata;
      step;
    end
    checks++;
    if (a_seen !== 16'h2ABC) begin
      errors++; $display("FAIL write_addr: got %h expected 2abc", a_seen);
    end
    for (int i = 0; i < 2; i++) begin
      if (m_breq !== 1'b1 || m_valid !== 1'b0) ok = 1'b0;
      s_ack = (i == 1);
      step;
    end
    s_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m_breq !== 1'b1 || m_valid !== 1'b1 || m_mode !== 1'b1) ok = 1'b0;
      w_seen[i] = m_wdata;
      step;
    end
    checks++;
    if (w_seen !== 8'h5A) begin
      errors++; $display("FAIL write_data: got %h expected 5a", w_seen);
    end
    for (int i = 0; i < 2; i++) begin
      if (m_breq !== 1'b1 || m_valid !== 1'b0 || d_done !== 1'b0) ok = 1'b0;
      s_ack = (i == 1);
      step;
    end
    s_ack = 1'b0;
    checks++;
    if ({d_done, d_err, m_breq, m_valid} !== 4'b1000) begin
      errors++; $display("FAIL write_done: done/err/breq/valid=%b expected 1000",
                         {d_done, d_err, m_breq, m_valid});
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL write_span: breq/valid/mode profile bad, got %b expected 1", ok);
    end
    step;
    checks++;
    if ({d_done, d_ready} !== 2'b01) begin
      errors++; $display("FAIL write_idle: done/ready=%b expected 01", {d_done, d_ready});
    end
  endtask

  task automatic test_read;
    logic [15:0] a_seen;
    logic [7:0]  rd;
    logic        ok;
    rd = 8'hC3; ok = 1'b1;
    d_req = 1'b1; d_addr = 16'h0123; d_mode = 1'b0; m_bgrant = 1'b1;
    step;
    d_req = 1'b0;
    step;
    for (int i = 0; i < 16; i++) begin
      a_seen[i] = m_wdata;
      if (m_mode !== 1'b0) ok = 1'b0;
      step;
    end
    checks++;
    if (a_seen !== 16'h0123) begin
      errors++; $display("FAIL read_addr: got %h expected 0123", a_seen);
    end
    s_ack = 1'b1;
    step;
    s_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 2; g++) begin
        s_rvalid = 1'b0;
        step;
        if (d_done !== 1'b0 || m_breq !== 1'b1 || m_valid !== 1'b0) ok = 1'b0;
      end
      if (i == 7) begin
        checks++;
        if (d_rdata !== 8'h00) begin
          errors++; $display("FAIL read_early: d_rdata=%h expected 00 before last bit", d_rdata);
        end
      end
      s_rvalid = 1'b1; s_rdata = rd[i];
      step;
    end
    s_rvalid = 1'b0;
    checks++;
    if ({d_done, d_err} !== 2'b10 || d_rdata !== 8'hC3) begin
      errors++; $display("FAIL read_done: done/err=%b rdata=%h expected 10 c3", {d_done, d_err}, d_rdata);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL read_span: gap profile bad, got %b expected 1", ok);
    end
    step; step; step;
    checks++;
    if (d_ready !== 1'b1 || d_rdata !== 8'hC3) begin
      errors++; $display("FAIL read_hold: ready=%b rdata=%h expected 1 c3", d_ready, d_rdata);
    end
  endtask

  task automatic test_timeout;
    logic ok;
    ok = 1'b1;
    d_req = 1'b1; d_addr = 16'h0042; d_mode = 1'b0; m_bgrant = 1'b1; s_ack = 1'b0;
    step;
    d_req = 1'b0;
    step;
    for (int i = 0; i < 16; i++) step;
    for (int k = 1; k <= 255; k++) begin
      step;
      if (d_done !== 1'b0 || m_breq !== 1'b1 || m_valid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL tmo_wait: early exit from AACK, got %b expected 1", ok);
    end
    step;
    checks++;
    if ({d_done, d_err} !== 2'b11) begin
      errors++; $display("FAIL tmo_done: done/err=%b expected 11 at AACK+256", {d_done, d_err});
    end
    checks++;
    if (d_rdata !== 8'hC3) begin
      errors++; $display("FAIL tmo_rdata: got %h expected c3", d_rdata);
    end
    step;
    checks++;
    if ({m_breq, d_done, d_ready} !== 3'b001) begin
      errors++; $display("FAIL tmo_after: breq/done/ready=%b expected 001", {m_breq, d_done, d_ready});
    end
  endtask

  task automatic test_grant_loss;
    d_req = 1'b1; d_addr = 16'h1234; d_mode = 1'b0; m_bgrant = 1'b1;
    step;
    d_req = 1'b0;
    step;
    for (int i = 0; i < 8; i++) step;
    checks++;
    if (m_valid !== 1'b1 || m_wdata !== 1'b0) begin
      errors++; $display("FAIL gl_bit8: valid/wdata=%b expected 10", {m_valid, m_wdata});
    end
    m_bgrant = 1'b0;
    step;
    checks++;
    if ({m_valid, d_done, d_err, m_breq} !== 4'b0110) begin
      errors++; $display("FAIL gl_done: valid/done/err/breq=%b expected 0110",
                         {m_valid, d_done, d_err, m_breq});
    end
    checks++;
    if (d_rdata !== 8'hC3) begin
      errors++; $display("FAIL gl_rdata: got %h expected c3", d_rdata);
    end
    m_bgrant = 1'b1;
    step;
    checks++;
    if (d_ready !== 1'b1 || d_done !== 1'b0) begin
      errors++; $display("FAIL gl_idle: ready/done=%b expected 10", {d_ready, d_done});
    end
  endtask

  task automatic test_back_to_back;
    int          lat;
    logic        err, ok;
    logic [15:0] a_seen;
    logic [7:0]  w_seen;
    run_txn(16'h0F0F, 8'h33, 1'b1, 8'h00, 5, lat, err, a_seen, w_seen);
    checks++;
    if (lat !== 28 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_wr_lat: latency=%0d err=%b expected 28 0", lat, err);
    end
    checks++;
    if (a_seen !== 16'h0F0F || w_seen !== 8'h33) begin
      errors++; $display("FAIL b2b_wr_bits: addr=%h data=%h expected 0f0f 33", a_seen, w_seen);
    end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      if (d_ready !== 1'b1 || m_breq !== 1'b0 || d_done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL b2b_no_second: spurious activity, got %b expected 1", ok);
    end
    run_txn(16'hBEEF, 8'h00, 1'b0, 8'h96, 10, lat, err, a_seen, w_seen);
    checks++;
    if (lat !== 27 || err !== 1'b0 || d_rdata !== 8'h96) begin
      errors++; $display("FAIL b2b_rd: latency=%0d err=%b rdata=%h expected 27 0 96", lat, err, d_rdata);
    end
    checks++;
    if (a_seen !== 16'hBEEF) begin
      errors++; $display("FAIL b2b_rd_addr: got %h expected beef", a_seen);
    end
    step;
    run_txn(16'h8001, 8'h01, 1'b1, 8'h00, -1, lat, err, a_seen, w_seen);
    checks++;
    if (lat !== 28 || err !== 1'b0 || a_seen !== 16'h8001 || w_seen !== 8'h01) begin
      errors++; $display("FAIL b2b_next: latency=%0d err=%b addr=%h data=%h expected 28 0 8001 01",
                         lat, err, a_seen, w_seen);
    end
    step;
  endtask

  task automatic test_reset_mid;
    int          lat;
    logic        err, ok;
    logic [15:0] a_seen;
    logic [7:0]  w_seen;
    d_req = 1'b1; d_addr = 16'h1357; d_wdata = 8'hA5; d_mode = 1'b1;
    m_bgrant = 1'b1; s_ack = 1'b1;
    for (int c = 0; c < 21; c++) begin
      step;
      d_req = 1'b0;
    end
    checks++;
    if (m_valid !== 1'b1 || m_breq !== 1'b1) begin
      errors++; $display("FAIL rstmid_wdata: valid/breq=%b expected 11", {m_valid, m_breq});
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if ({d_ready, m_breq, m_valid, m_wdata, m_mode, d_done, d_err} !== 7'b1000000 ||
        d_rdata !== 8'h00) begin
      errors++; $display("FAIL rstmid_outs: ctrl=%b rdata=%h expected 1000000 00",
                         {d_ready, m_breq, m_valid, m_wdata, m_mode, d_done, d_err}, d_rdata);
    end
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step;
      if (d_done !== 1'b0 || m_breq !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL rstmid_quiet: activity after reset, got %b expected 1", ok);
    end
    run_txn(16'h2468, 8'h7E, 1'b1, 8'h00, -1, lat, err, a_seen, w_seen);
    checks++;
    if (lat !== 28 || err !== 1'b0 || a_seen !== 16'h2468 || w_seen !== 8'h7E) begin
      errors++; $display("FAIL rstmid_next: latency=%0d err=%b addr=%h data=%h expected 28 0 2468 7e",
                         lat, err, a_seen, w_seen);
    end
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_grant_loss;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
